reorder_merger_rd: RTL
======================

Name: reorder_merger_rd

Overview:
- Read-data merger sitting directly downstream of the read address splitter.
- The splitter interleaves each AXI read burst beat-by-beat (128-byte beats) across two channels and pushes a sequence entry {arlen, first_channel} per burst. This block consumes that sequence queue and the two per-channel R streams.
- It re-interleaves the beats into the original order and presents one AXI R stream to the requester.

Parameters:
- DATA_BITS, 1024, width of one R beat (one 128-byte cache line).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- mux_r  metaIntf.s  9  sequence entry; data[8:1]=arlen, data[0]=first_channel (1 = burst starts on channel 1)
- axi_in_rdata  in  [1:0][DATA_BITS]  per-channel read data
- axi_in_rresp  in  [1:0][2]  per-channel response
- axi_in_rlast  in  [1:0]  per-channel last
- axi_in_rvalid  in  [1:0]  per-channel valid
- axi_in_rready  out  [1:0]  per-channel ready
- axi_out_rdata  out  DATA_BITS  merged data
- axi_out_rresp  out  2  merged response
- axi_out_rlast  out  1  merged last
- axi_out_rvalid  out  1  merged valid
- axi_out_rready  in  1  merged ready
- err_rlast  out  1  sticky protocol error flag

Behaviour:
- Reset (async, aresetn=0): state=IDLE, beat counter=0, output register empty. Outputs: axi_out_rvalid=0, axi_out_rlast=0, axi_out_rresp=0, axi_out_rdata=0, axi_in_rready=0, mux_r.ready=0, err_rlast=0. Reset mid-burst discards all burst state; sequence entries already popped are lost.
- State machine:
  - IDLE: mux_r.ready=1. On mux_r.valid, latch len=data[8:1] and first=data[0], clear beat=0, go to STREAM.
  - STREAM: sel = first ^ beat[0]. Only channel sel may be accepted: axi_in_rready[sel] = load_en, axi_in_rready[~sel]=0.
  - load_en = ~out_valid | axi_out_rready (single output register, pass-through ready).
  - On a transfer (axi_in_rvalid[sel] & load_en): capture rdata/rresp[sel] into the output register. Set axi_out_rlast = (beat==len) and beat++.
  - On a transfer with beat==len: if mux_r.valid in the same cycle, mux_r.ready=1, load the new len/first, clear beat and stay in STREAM (no bubble). Otherwise go to IDLE.
  - mux_r.ready is 0 in STREAM except on that last-beat transfer cycle.
- Latency: 1 cycle from an input transfer to axi_out_rvalid. Full throughput of 1 beat/cycle under continuous rready.
- Output register holds data, resp and last stable while axi_out_rvalid & ~axi_out_rready.
- Arithmetic: beat and len are 8 bits. len=255 gives 256 beats, and beat==len terminates before any wrap. Burst beat count is len+1. Channel first gets ceil((len+1)/2) beats, the other channel floor((len+1)/2).
- Input rlast check:
  - expected = (beat==len) | (len!=0 & beat==len-1).
  - On any accepted beat where axi_in_rlast[sel] != expected, set err_rlast=1.
  - err_rlast clears only on reset. Data flow is unaffected and axi_out_rlast always comes from the counter.
- rresp passes through per beat unmodified.
- Simultaneous: valid on the non-selected channel is ignored (held by the upstream FIFO). A sequence entry arriving while the burst is incomplete waits.
- An empty sequence queue in IDLE produces no input readies, so stray channel beats stall.

Test Plan:
- len=0, first=0, ch0 beat D0 -> one output beat D0 with rlast=1, 1 cycle later. ch1 never readied. err_rlast=0.
- len=0, first=1, ch1 beat D0 (rlast=1) -> output D0 rlast=1. State returns to IDLE.
- len=3, first=1. ch1 offers A,C (rlast on C); ch0 offers B,D (rlast on D), both valid from cycle 0 -> output order A,B,C,D with rlast only on D, 4 consecutive cycles.
- len=4, first=0, axi_out_rready toggling 1,0,0,1,... -> output order ch0,ch1,ch0,ch1,ch0. Data held stable during stalls, no beat lost or duplicated, rlast on the 5th beat.
- Two entries queued (len=1,first=0 then len=1,first=1) with all data available -> 4 beats on 4 consecutive cycles, with no bubble between bursts. Output order ch0,ch1,ch1,ch0, rlast on beats 2 and 4.
- len=3, first=0, ch0 asserts rlast on its first beat -> err_rlast=1 from the next cycle and stays set. Output stream unchanged.
- Assert aresetn=0 after 2 of 4 beats -> all outputs go to reset values immediately. After release the block accepts a fresh len=0 entry normally.

Source files
------------

// File: rtl/reorder_merger_rd.sv
// Read-data merger: rebuilds the original AXI R beat order from two channel R streams,
// driven by {arlen, first_channel} sequence entries from the read address splitter.
module reorder_merger_rd #(
  parameter int unsigned DATA_BITS = 1024
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      mux_r_valid,
  output logic                      mux_r_ready,
  input  logic [8:0]                mux_r_data,
  input  logic [1:0][DATA_BITS-1:0] axi_in_rdata,
  input  logic [1:0][1:0]           axi_in_rresp,
  input  logic [1:0]                axi_in_rlast,
  input  logic [1:0]                axi_in_rvalid,
  output logic [1:0]                axi_in_rready,
  output logic [DATA_BITS-1:0]      axi_out_rdata,
  output logic [1:0]                axi_out_rresp,
  output logic                      axi_out_rlast,
  output logic                      axi_out_rvalid,
  input  logic                      axi_out_rready,
  output logic                      err_rlast
);

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned RESP_W = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e               state_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     beat_q;
  logic                 first_q;
  logic                 out_valid_q;
  logic [DATA_BITS-1:0] out_data_q;
  logic [RESP_W-1:0]    out_resp_q;
  logic                 out_last_q;
  logic                 err_q;

  logic sel_c;
  logic load_en_c;
  logic xfer_c;
  logic last_beat_c;
  logic rlast_exp_c;

  // Beats alternate channels starting from the burst's first channel.
  assign sel_c       = first_q ^ beat_q[0];
  assign load_en_c   = ~out_valid_q | axi_out_rready;
  assign xfer_c      = (state_q == STREAM) & axi_in_rvalid[sel_c] & load_en_c;
  assign last_beat_c = (beat_q == len_q);
  // Each channel's final beat is either the burst's last or the one just before it.
  assign rlast_exp_c = last_beat_c | ((len_q != LEN_W'(0)) && (beat_q == len_q - LEN_W'(1)));

  always_comb begin
    axi_in_rready = '0;
    if (state_q == STREAM) axi_in_rready[sel_c] = load_en_c;
  end

  // Next entry is taken in IDLE or on the last beat of a burst, giving back-to-back bursts.
  assign mux_r_ready = aresetn & ((state_q == IDLE) | (xfer_c & last_beat_c));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      len_q       <= '0;
      beat_q      <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_resp_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (xfer_c) begin
        out_valid_q <= 1'b1;
        out_data_q  <= axi_in_rdata[sel_c];
        out_resp_q  <= axi_in_rresp[sel_c];
        out_last_q  <= last_beat_c;
        beat_q      <= beat_q + LEN_W'(1);
        if (axi_in_rlast[sel_c] != rlast_exp_c) err_q <= 1'b1;
      end else if (load_en_c) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (mux_r_valid) begin
            len_q   <= mux_r_data[8:1];
            first_q <= mux_r_data[0];
            beat_q  <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (xfer_c && last_beat_c) begin
            if (mux_r_valid) begin
              len_q   <= mux_r_data[8:1];
              first_q <= mux_r_data[0];
              beat_q  <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign axi_out_rdata  = out_data_q;
  assign axi_out_rresp  = out_resp_q;
  assign axi_out_rlast  = out_last_q;
  assign axi_out_rvalid = out_valid_q;
  assign err_rlast      = err_q;

endmodule
